// File: rtl/serial_addsub_unit.sv
// serial_addsub_unit: digit-serial two's-complement adder/subtractor with valid/ready handshake.
// Define SERIAL_ADDSUB_SATURATE_EN to saturate the result on signed overflow.
module serial_addsub_unit #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subtract,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW = NDIG > 1 ? $clog2(NDIG) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] a_q, b_q, res_next, res_final;
  logic [CW-1:0] cnt;
  logic carry, last, c_msb, ovf_next;
  logic [DIGIT:0] sum;
  logic [DIGIT-1:0] a_d, b_d;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    a_d = a_q[cnt*DIGIT +: DIGIT];
    b_d = b_q[cnt*DIGIT +: DIGIT];
    sum = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, carry};
    res_next = result;
    res_next[cnt*DIGIT +: DIGIT] = sum[DIGIT-1:0];
    last = cnt == CW'(NDIG - 1);
    // carry into the MSB recovered from the MSB sum bit and its operand bits
    c_msb = a_d[DIGIT-1] ^ b_d[DIGIT-1] ^ sum[DIGIT-1];
    ovf_next = c_msb ^ sum[DIGIT];
`ifdef SERIAL_ADDSUB_SATURATE_EN
    res_final = !ovf_next ? res_next :
                a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    res_final = res_next;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      carry <= 1'b0;
      cnt <= '0;
      result <= '0;
      cout <= 1'b0;
      overflow <= 1'b0;
      zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q <= a;
          b_q <= subtract ? ~b : b;
          carry <= subtract;
          cnt <= '0;
          state <= CALC;
        end
        CALC: begin
          carry <= sum[DIGIT];
          cnt <= cnt + 1'b1;
          result <= last ? res_final : res_next;
          if (last) begin
            cout <= sum[DIGIT];
            overflow <= ovf_next;
            zero <= res_final == '0;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
